// File: rtl/lsu_pkg.sv
// Shared types and helpers for the LSU bank controller: access size, FSM states,
// byte-lane mask generation and load sign/zero extension.
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_ILL  = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ACC0 = 2'b01,
      ACC1 = 2'b10,
      RSP  = 2'b11
   } state_e;

   // Lanes over the pair {word A+1, word A}; bits [7:4] set means the access spills into A+1.
   function automatic logic [7:0] lane_mask(input size_e size, input logic [1:0] off);
      logic [7:0] base;
      case (size)
         SZ_BYTE: base = 8'b0000_0001;
         SZ_HALF: base = 8'b0000_0011;
         SZ_WORD: base = 8'b0000_1111;
         default: base = 8'b0000_0000;
      endcase
      return base << off;
   endfunction

   function automatic logic [31:0] extend(input logic [31:0] raw, input size_e size,
                                          input logic uns);
      logic [31:0] res;
      case (size)
         SZ_BYTE: res = uns ? {24'h0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
         SZ_HALF: res = uns ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
         default: res = raw;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: shifts store data onto the addressed byte lanes of the
// current bank word (read-modify-write merge) and gathers/extends load bytes.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  size_e       i_size,
   input  logic [1:0]  i_off,
   input  logic        i_unsigned,
   input  logic        i_hi,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rd_word,
   input  logic [31:0] i_lo_word,
   output logic [31:0] o_merged,
   output logic [31:0] o_load
);

   logic [7:0]  mask;
   logic [3:0]  lanes;
   logic [63:0] wdata_sh;
   logic [31:0] wdata_word;
   logic [63:0] rd_pair;
   logic [31:0] rd_lo;

   // NOTE: every output and temporary is fully assigned on every pass, so no latch can form.
   always_comb begin
      mask       = lane_mask(i_size, i_off);
      wdata_sh   = {32'h0, i_wdata} << {i_off, 3'b000};
      lanes      = i_hi ? mask[7:4] : mask[3:0];
      wdata_word = i_hi ? wdata_sh[63:32] : wdata_sh[31:0];
      for (int i = 0; i < 4; i++) begin
         o_merged[8*i +: 8] = lanes[i] ? wdata_word[8*i +: 8] : i_rd_word[8*i +: 8];
      end
      // In the second access the first word comes from the captured copy of word A.
      rd_pair = i_hi ? {i_rd_word, i_lo_word} : {32'h0, i_rd_word};
      rd_lo   = 32'(rd_pair >> {i_off, 3'b000});
      o_load  = extend(rd_lo, i_size, i_unsigned);
   end

endmodule

// File: rtl/lsu_bank_ctrl.sv
// Load/store controller for a single-port word bank with byte/half/word accesses.
// Optional macro LSU_MISALIGN_EN enables word-crossing accesses through a second ACC1 cycle.
module lsu_bank_ctrl
   import lsu_pkg::*;
#(
   parameter int ADDRBIT = 14
)(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_req_valid,
   output logic               o_req_ready,
   input  logic               i_req_wr,
   input  logic [31:0]        i_req_addr,
   input  logic [1:0]         i_req_size,
   input  logic               i_req_unsigned,
   input  logic [31:0]        i_req_wdata,
   output logic               o_rsp_valid,
   output logic [31:0]        o_rsp_rdata,
   output logic               o_rsp_err,
   output logic [ADDRBIT-3:0] o_bank_addr,
   output logic [31:0]        o_bank_wdata,
   output logic               o_bank_wren,
   input  logic [31:0]        i_bank_rdata
);

   localparam int AW = ADDRBIT - 2;

   state_e        state_q, state_d;
   logic          wr_q, wr_d;
   logic [31:0]   addr_q, addr_d;
   size_e         size_q, size_d;
   logic          uns_q, uns_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   rdata_q, rdata_d;
`ifdef LSU_MISALIGN_EN
   logic [31:0]   lo_q, lo_d;
`endif

   logic [AW-1:0] word_addr;
   logic [7:0]    mask;
   logic          misaligned;
   logic          acc_err;
   logic          use_hi;
   logic [31:0]   lo_word;
   logic [31:0]   merged;
   logic [31:0]   load_data;

   always_comb begin
      word_addr  = addr_q[ADDRBIT-1:2];
      mask       = lane_mask(size_q, addr_q[1:0]);
      misaligned = |mask[7:4];
      acc_err    = (size_q == SZ_ILL) || (addr_q[31:ADDRBIT] != '0);
`ifdef LSU_MISALIGN_EN
      // No wrap-around: a spill past the last bank word faults.
      acc_err    = acc_err || (misaligned && (word_addr == '1));
      use_hi     = (state_q == ACC1);
      lo_word    = lo_q;
`else
      acc_err    = acc_err || misaligned;
      use_hi     = 1'b0;
      lo_word    = '0;
`endif
   end

   lsu_lane_align u_align (
      .i_size     (size_q),
      .i_off      (addr_q[1:0]),
      .i_unsigned (uns_q),
      .i_hi       (use_hi),
      .i_wdata    (wdata_q),
      .i_rd_word  (i_bank_rdata),
      .i_lo_word  (lo_word),
      .o_merged   (merged),
      .o_load     (load_data)
   );

   always_comb begin
      state_d      = state_q;
      wr_d         = wr_q;
      addr_d       = addr_q;
      size_d       = size_q;
      uns_d        = uns_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
`ifdef LSU_MISALIGN_EN
      lo_d         = lo_q;
`endif
      o_req_ready  = 1'b0;
      o_rsp_valid  = 1'b0;
      o_rsp_err    = 1'b0;
      o_rsp_rdata  = '0;
      o_bank_addr  = '0;
      o_bank_wdata = '0;
      o_bank_wren  = 1'b0;

      case (state_q)
         IDLE: begin
            o_req_ready = !i_rst;
            if (i_req_valid) begin
               wr_d    = i_req_wr;
               addr_d  = i_req_addr;
               size_d  = size_e'(i_req_size);
               uns_d   = i_req_unsigned;
               wdata_d = i_req_wdata;
               state_d = ACC0;
            end
         end
         ACC0: begin
            o_bank_addr  = word_addr;
            o_bank_wdata = merged;
            o_bank_wren  = wr_q && !acc_err;
            rdata_d      = (wr_q || acc_err) ? '0 : load_data;
`ifdef LSU_MISALIGN_EN
            lo_d         = i_bank_rdata;
            state_d      = (misaligned && !acc_err) ? ACC1 : RSP;
`else
            state_d      = RSP;
`endif
         end
`ifdef LSU_MISALIGN_EN
         ACC1: begin
            o_bank_addr  = word_addr + AW'(1);
            o_bank_wdata = merged;
            o_bank_wren  = wr_q && !acc_err;
            rdata_d      = (wr_q || acc_err) ? '0 : load_data;
            state_d      = RSP;
         end
`endif
         RSP: begin
            o_rsp_valid = 1'b1;
            o_rsp_err   = acc_err;
            o_rsp_rdata = rdata_q;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         size_q  <= SZ_BYTE;
         uns_q   <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
`ifdef LSU_MISALIGN_EN
         lo_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
`ifdef LSU_MISALIGN_EN
         lo_q    <= lo_d;
`endif
      end
   end

endmodule

// File: tb/tb_lsu_bank_ctrl.sv
// Self-checking bench for lsu_bank_ctrl: directed scenarios plus random traffic against a
// byte-array reference model; expectations follow LSU_MISALIGN_EN when it is defined.
`timescale 1ns/1ps
module tb_lsu_bank_ctrl;

   localparam int ADDRBIT = 14;
   localparam int AW      = ADDRBIT - 2;
   localparam int NWORDS  = 1 << AW;
   localparam int NBYTES  = 1 << ADDRBIT;
`ifdef LSU_MISALIGN_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif

   logic          i_clk = 1'b0;
   logic          i_rst;
   logic          i_req_valid;
   logic          o_req_ready;
   logic          i_req_wr;
   logic [31:0]   i_req_addr;
   logic [1:0]    i_req_size;
   logic          i_req_unsigned;
   logic [31:0]   i_req_wdata;
   logic          o_rsp_valid;
   logic [31:0]   o_rsp_rdata;
   logic          o_rsp_err;
   logic [AW-1:0] o_bank_addr;
   logic [31:0]   o_bank_wdata;
   logic          o_bank_wren;
   logic [31:0]   i_bank_rdata;

   lsu_bank_ctrl #(.ADDRBIT(ADDRBIT)) dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_req_valid    (i_req_valid),
      .o_req_ready    (o_req_ready),
      .i_req_wr       (i_req_wr),
      .i_req_addr     (i_req_addr),
      .i_req_size     (i_req_size),
      .i_req_unsigned (i_req_unsigned),
      .i_req_wdata    (i_req_wdata),
      .o_rsp_valid    (o_rsp_valid),
      .o_rsp_rdata    (o_rsp_rdata),
      .o_rsp_err      (o_rsp_err),
      .o_bank_addr    (o_bank_addr),
      .o_bank_wdata   (o_bank_wdata),
      .o_bank_wren    (o_bank_wren),
      .i_bank_rdata   (i_bank_rdata)
   );

   always #5 i_clk = ~i_clk;

   // Attached bank and event counters.
   logic [31:0] bank [NWORDS];
   logic        tb_clear;
   int          wren_cnt = 0;
   int          rsp_cnt  = 0;
   logic [31:0] last_wdata = '0;

   assign i_bank_rdata = bank[o_bank_addr];

   always @(posedge i_clk) begin
      if (tb_clear) begin
         for (int i = 0; i < NWORDS; i++) bank[i] <= '0;
      end else if (o_bank_wren) begin
         bank[o_bank_addr] <= o_bank_wdata;
      end
      if (o_bank_wren) begin
         wren_cnt   <= wren_cnt + 1;
         last_wdata <= o_bank_wdata;
      end
      if (o_rsp_valid) rsp_cnt <= rsp_cnt + 1;
   end

   // Reference: flat byte memory, little-endian.
   logic [7:0] ref_mem [NBYTES];
   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic model(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata,
                        output logic exp_err, output logic [31:0] exp_rd,
                        output int exp_lat, output int exp_wr);
      int      nb;
      int      off;
      bit      mis;
      longint  a;
      longint  v;
      nb      = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      off     = int'(addr[1:0]);
      mis     = (off + nb) > 4;
      a       = longint'(addr);
      exp_err = (size == 2'd3) || (a + nb > NBYTES) || (mis && !MIS_EN);
      exp_rd  = '0;
      exp_wr  = 0;
      exp_lat = (mis && !exp_err) ? 3 : 2;
      if (!exp_err) begin
         if (wr) begin
            for (int i = 0; i < nb; i++) ref_mem[addr + i] = wdata[8*i +: 8];
            exp_wr = mis ? 2 : 1;
         end else begin
            v = 0;
            for (int i = 0; i < nb; i++) v += longint'(ref_mem[addr + i]) << (8 * i);
            if (!uns && v >= (longint'(1) << (8 * nb - 1))) v -= longint'(1) << (8 * nb);
            exp_rd = v[31:0];
         end
      end
   endtask

   // Issues one request starting at a negedge and returns at the negedge of its response cycle.
   task automatic do_req(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                         output logic [31:0] got_rd);
      logic        exp_err;
      logic [31:0] exp_rd;
      int          exp_lat, exp_wr;
      int          w0, lat, wait_cyc;
      bit          seen;
      logic        got_err;
      model(wr, addr, size, uns, wdata, exp_err, exp_rd, exp_lat, exp_wr);
      @(negedge i_clk);
      wait_cyc = 0;
      while (!o_req_ready && wait_cyc < 10) begin
         @(negedge i_clk);
         wait_cyc++;
      end
      check({tag, ":ready"}, 32'(o_req_ready), 32'd1);
      w0             = wren_cnt;
      i_req_valid    = 1'b1;
      i_req_wr       = wr;
      i_req_addr     = addr;
      i_req_size     = size;
      i_req_unsigned = uns;
      i_req_wdata    = wdata;
      @(negedge i_clk);
      i_req_valid = 1'b0;
      lat     = 1;
      seen    = 1'b0;
      got_err = 1'b0;
      got_rd  = '0;
      while (!seen && lat < 8) begin
         if (o_rsp_valid) begin
            seen    = 1'b1;
            got_err = o_rsp_err;
            got_rd  = o_rsp_rdata;
         end else begin
            @(negedge i_clk);
            lat++;
         end
      end
      check({tag, ":rsp_seen"}, 32'(seen), 32'd1);
      check({tag, ":latency"}, 32'(lat), 32'(exp_lat));
      check({tag, ":err"}, 32'(got_err), 32'(exp_err));
      check({tag, ":rdata"}, got_rd, exp_rd);
      check({tag, ":wrens"}, 32'(wren_cnt - w0), 32'(exp_wr));
      check({tag, ":busy"}, 32'(o_req_ready), 32'd0);
   endtask

   initial begin : main
      logic [31:0] rd;
      int          w0, r0, mism;
      logic [31:0] exp_word;
      logic        r_wr, r_uns;
      logic [1:0]  r_size;
      logic [31:0] r_addr;
      int          sel;

      for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'h00;
      i_rst = 1'b1; tb_clear = 1'b1;
      i_req_valid = 1'b0; i_req_wr = 1'b0; i_req_addr = '0;
      i_req_size = 2'b00; i_req_unsigned = 1'b0; i_req_wdata = '0;
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      check("rst_ready",     32'(o_req_ready), 32'd0);
      check("rst_wren",      32'(o_bank_wren), 32'd0);
      check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
      check("rst_rsp_err",   32'(o_rsp_err),   32'd0);
      check("rst_rsp_rdata", o_rsp_rdata,      32'd0);
      tb_clear = 1'b0;
      i_rst    = 1'b0;
      #1;
      check("rel_ready",      32'(o_req_ready), 32'd1);
      check("idle_bank_addr", 32'(o_bank_addr), 32'd0);
      check("idle_bank_data", o_bank_wdata,     32'd0);

      // Store byte into a preloaded word.
      do_req("pre_w4", 1'b1, 32'h10, 2'b10, 1'b0, 32'h11223344, rd);
      do_req("sb_11",  1'b1, 32'h11, 2'b00, 1'b0, 32'h000000AA, rd);
      check("sb_11:merged", last_wdata, 32'h1122AA44);

      // Signed/unsigned loads.
      do_req("lh_12", 1'b0, 32'h12, 2'b01, 1'b0, 32'h0, rd);
      check("lh_12:lit", rd, 32'h00001122);
      do_req("sb_13", 1'b1, 32'h13, 2'b00, 1'b0, 32'h00000080, rd);
      do_req("lb_13", 1'b0, 32'h13, 2'b00, 1'b0, 32'h0, rd);
      check("lb_13:lit", rd, 32'hFFFFFF80);
      do_req("lbu_13", 1'b0, 32'h13, 2'b00, 1'b1, 32'h0, rd);
      check("lbu_13:lit", rd, 32'h00000080);

      // Word-crossing load and store.
      do_req("pre_w4b", 1'b1, 32'h10, 2'b10, 1'b0, 32'h11223344, rd);
      do_req("pre_w5",  1'b1, 32'h14, 2'b10, 1'b0, 32'h55667788, rd);
      do_req("lw_13",   1'b0, 32'h13, 2'b10, 1'b0, 32'h0, rd);
      check("lw_13:lit", rd, MIS_EN ? 32'h66778811 : 32'h0);
      do_req("sh_17",   1'b1, 32'h17, 2'b01, 1'b0, 32'h0000BEEF, rd);
      do_req("lw_14",   1'b0, 32'h14, 2'b10, 1'b0, 32'h0, rd);
      do_req("lw_18",   1'b0, 32'h18, 2'b10, 1'b0, 32'h0, rd);

      // Range, crossing and illegal-size faults; last valid byte.
      do_req("sw_4000",  1'b1, 32'h4000,     2'b10, 1'b0, 32'hCAFEF00D, rd);
      do_req("lw_3ffe",  1'b0, 32'h3FFE,     2'b10, 1'b0, 32'h0, rd);
      do_req("sh_3fff",  1'b1, 32'h3FFF,     2'b01, 1'b0, 32'h00001234, rd);
      do_req("sb_3fff",  1'b1, 32'h3FFF,     2'b00, 1'b0, 32'h000000C3, rd);
      do_req("lb_3fff",  1'b0, 32'h3FFF,     2'b00, 1'b0, 32'h0, rd);
      do_req("ill_size", 1'b1, 32'h20,       2'b11, 1'b0, 32'h12345678, rd);
      do_req("lw_hiadr", 1'b0, 32'h8000_0010, 2'b10, 1'b0, 32'h0, rd);

      // Reset in the ACC0 cycle of a store aborts it.
      @(negedge i_clk);
      w0 = wren_cnt;
      r0 = rsp_cnt;
      i_req_valid = 1'b1; i_req_wr = 1'b1; i_req_addr = 32'h20;
      i_req_size = 2'b10; i_req_unsigned = 1'b0; i_req_wdata = 32'hDEADBEEF;
      @(negedge i_clk);
      i_req_valid = 1'b0;
      check("abort:acc0_wren", 32'(o_bank_wren), 32'd1);
      #1 i_rst = 1'b1;
      #1;
      check("abort:rst_wren",  32'(o_bank_wren), 32'd0);
      check("abort:rst_ready", 32'(o_req_ready), 32'd0);
      check("abort:rst_rsp",   32'(o_rsp_valid), 32'd0);
      @(posedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0;
      @(posedge i_clk);
      #1;
      check("abort:ready_after", 32'(o_req_ready), 32'd1);
      repeat (3) @(negedge i_clk);
      check("abort:no_wren", 32'(wren_cnt - w0), 32'd0);
      check("abort:no_rsp",  32'(rsp_cnt - r0),  32'd0);
      do_req("b2b_0", 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, rd);
      do_req("b2b_1", 1'b1, 32'h24, 2'b01, 1'b0, 32'h0000A5A5, rd);

      // Random traffic.
      for (int k = 0; k < 40; k++) begin
         r_wr   = 1'($urandom_range(0, 1));
         r_uns  = 1'($urandom_range(0, 1));
         r_size = 2'($urandom_range(0, 3));
         sel    = int'($urandom_range(0, 9));
         if (sel < 6)      r_addr = 32'($urandom_range(0, 63));
         else if (sel < 9) r_addr = 32'h3FF0 + 32'($urandom_range(0, 15));
         else              r_addr = 32'h4000 + 32'($urandom_range(0, 4095));
         do_req($sformatf("rnd%0d", k), r_wr, r_addr, r_size, r_uns, $urandom, rd);
      end

      // Whole bank image against the reference bytes.
      @(negedge i_clk);
      mism = 0;
      for (int w = 0; w < NWORDS; w++) begin
         exp_word = {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
         if (bank[w] !== exp_word) mism++;
      end
      check("mem_image", 32'(mism), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
